// File: rtl/fsqrt_pipe_hs.sv
// fsqrt_pipe_hs -- pipelined binary32 square root with valid/ready flow control.
//
// Stage p0 classifies the operand and builds a 50-bit fixed-point radicand.
// Stages p1..p3 run a restoring integer square root (9 + 8 + 8 = 25 result
// bits). Stage p4 rounds to 24 significant bits, applies the special-case
// override and forms the result. LAT-5 extra registers trail p4, and the last
// register of that chain drives the outputs. A single enable stalls the whole
// pipe whenever the output holds an unaccepted result.
//
// Parameters
//   LAT       accept-to-out_valid latency with no stall (>= 5)
//   TAG_W     width of the tag sideband
//   IEEE_EXC  1: full NaN/inf/negative handling, 0: legacy (sign ignored)
// Ports
//   clk, rstn            clock, synchronous active-low reset
//   flush                drop every in-flight operation
//   in_valid/in_ready    operand handshake; in_x operand, in_tag sideband
//   out_valid/out_ready  result handshake; out_y result, out_tag, out_inv
module fsqrt_pipe_hs #(
  parameter int LAT      = 5,
  parameter int TAG_W    = 5,
  parameter int IEEE_EXC = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_x,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_inv
);

  localparam int NT = LAT - 4;  // p4 plus the tail registers

  localparam logic [1:0] C_NORM = 2'd0;
  localparam logic [1:0] C_ZERO = 2'd1;
  localparam logic [1:0] C_INF  = 2'd2;
  localparam logic [1:0] C_NAN  = 2'd3;

  typedef struct packed {
    logic [49:0] rad;   // radicand bits not yet consumed, MSB pair first
    logic [27:0] rem;   // partial remainder
    logic [24:0] root;  // partial root
  } sq_t;

  typedef struct packed {
    sq_t              sq;
    logic [7:0]       ye;
    logic [1:0]       cls;
    logic             sgn;
    logic             inv;
    logic [TAG_W-1:0] tag;
  } st_t;

  // n iterations of the restoring square root, one result bit each
  function automatic sq_t sq_steps(input sq_t s, input int n);
    sq_t        r;
    logic [27:0] trial;
    r = s;
    for (int i = 0; i < n; i++) begin
      r.rem = {r.rem[25:0], r.rad[49:48]};
      r.rad = {r.rad[47:0], 2'b00};
      trial = {1'b0, r.root, 2'b01};
      if (r.rem >= trial) begin
        r.rem  = r.rem - trial;
        r.root = {r.root[23:0], 1'b1};
      end else begin
        r.root = {r.root[23:0], 1'b0};
      end
    end
    return r;
  endfunction

  function automatic st_t adv(input st_t s, input int n);
    st_t r;
    r    = s;
    r.sq = sq_steps(s.sq, n);
    return r;
  endfunction

  // The 25-bit root carries one guard bit below the 24-bit significand.
  // A tie is impossible (the radicand is even, so an exact root cannot be
  // odd), and the largest root never carries out of the significand.
  function automatic logic [22:0] rnd_man(input logic [23:0] r);
    return r[23:1] + {22'd0, r[0]};
  endfunction

  function automatic logic [31:0] res_y(input st_t s);
    logic [31:0] y;
    case (s.cls)
      C_ZERO:  y = {s.sgn, 31'd0};
      C_INF:   y = 32'h7F80_0000;
      C_NAN:   y = 32'h7FC0_0000;
      default: y = {1'b0, s.ye, rnd_man(s.sq.root[23:0])};
    endcase
    return y;
  endfunction

  logic en;
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  logic [7:0]  ex;
  logic [22:0] mx;
  logic        sx;
  logic [8:0]  ysum;
  st_t         s0_nxt;

  assign sx   = in_x[31];
  assign ex   = in_x[30:23];
  assign mx   = in_x[22:0];
  assign ysum = {1'b0, ex} + 9'd126 + {8'd0, ex[0]};

  // An odd biased exponent means an even unbiased one: the radicand is
  // {1,m} with its binary point shifted one place less than the odd case,
  // so the root always lands in [2^24, 2^25).
  always_comb begin
    s0_nxt        = '0;
    s0_nxt.tag    = in_tag;
    s0_nxt.ye     = ysum[8:1];
    s0_nxt.sq.rad = ex[0] ? {2'b01, mx, 25'd0} : {1'b1, mx, 26'd0};
    s0_nxt.cls    = C_NORM;
    s0_nxt.sgn    = 1'b0;
    s0_nxt.inv    = 1'b0;
    if (IEEE_EXC != 0) begin
      if (ex == 8'd0) begin
        s0_nxt.cls = C_ZERO;
        s0_nxt.sgn = sx;
      end else if (ex == 8'hFF) begin
        if (mx == 23'd0) begin
          s0_nxt.cls = sx ? C_NAN : C_INF;
          s0_nxt.inv = sx;
        end else begin
          s0_nxt.cls = C_NAN;
          s0_nxt.inv = ~mx[22];
        end
      end else if (sx) begin
        s0_nxt.cls = C_NAN;
        s0_nxt.inv = 1'b1;
      end
    end else if (ex == 8'd0) begin
      s0_nxt.cls = C_ZERO;
    end
  end

  logic             vld_p0, vld_p1, vld_p2, vld_p3;
  logic [NT-1:0]    vld_p4;
  st_t              st_p0, st_p1, st_p2, st_p3;
  logic [31:0]      y_p4   [NT];
  logic [TAG_W-1:0] tag_p4 [NT];
  logic [NT-1:0]    inv_p4;

  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
      vld_p4 <= '0;
    end else if (en) begin
      vld_p0    <= in_valid;
      vld_p1    <= vld_p0;
      vld_p2    <= vld_p1;
      vld_p3    <= vld_p2;
      vld_p4[0] <= vld_p3;
      for (int i = 1; i < NT; i++) vld_p4[i] <= vld_p4[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      // p0: classified operand and radicand
      st_p0 <= s0_nxt;
      // p1..p3: root bits 24..16, 15..8, 7..0
      st_p1 <= adv(st_p0, 9);
      st_p2 <= adv(st_p1, 8);
      st_p3 <= adv(st_p2, 8);
      // p4: rounding and special-case override, then tail
      y_p4[0]   <= res_y(st_p3);
      tag_p4[0] <= st_p3.tag;
      inv_p4[0] <= st_p3.inv;
      for (int i = 1; i < NT; i++) begin
        y_p4[i]   <= y_p4[i-1];
        tag_p4[i] <= tag_p4[i-1];
        inv_p4[i] <= inv_p4[i-1];
      end
    end
    // Only the register feeding the outputs has a defined reset value.
    if (!rstn) begin
      y_p4[NT-1]   <= '0;
      tag_p4[NT-1] <= '0;
      inv_p4[NT-1] <= 1'b0;
    end
  end

  logic unused_p3;
  assign unused_p3 = ^{st_p3.sq.rad, st_p3.sq.rem, st_p3.sq.root[24]};

  assign out_valid = vld_p4[NT-1];
  assign out_y     = y_p4[NT-1];
  assign out_tag   = tag_p4[NT-1];
  assign out_inv   = inv_p4[NT-1];

endmodule

// File: tb/tb_fsqrt_pipe_hs.sv
module tb_fsqrt_pipe_hs;
  localparam int LAT   = 5;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rstn, flush, in_valid, in_ready, out_valid, out_ready, out_inv;
  logic [31:0]      in_x, out_y;
  logic [TAG_W-1:0] in_tag, out_tag;

  always #5 clk = ~clk;

  fsqrt_pipe_hs #(.LAT(LAT), .TAG_W(TAG_W), .IEEE_EXC(1)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_tag(out_tag), .out_inv(out_inv)
  );

  int checks = 0, failures = 0, cyc = 0;

  typedef struct {
    logic [31:0]      y;
    logic [TAG_W-1:0] tag;
    logic             inv;
    int               tol;
    int               acc;
    bit               lat;
  } exp_t;

  exp_t q[$];
  bit   lat_mode = 0, exact_mode = 0, last_acc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp, input int tol);
    logic [63:0] d;
    checks++;
    d = (obs > exp) ? obs - exp : exp - obs;
    if ($isunknown(obs) || d > 64'(tol)) begin
      failures++;
      $display("FAIL %s: got %h, expected %h (tol %0d) at cycle %0d", tag, obs, exp, tol, cyc);
    end
  endtask

  // Round a positive double to binary32, nearest-even.
  function automatic logic [31:0] r2f(input real r);
    logic [63:0] b;
    logic [10:0] de;
    logic [7:0]  fe;
    logic [22:0] keep;
    logic        up;
    logic [30:0] v;
    b    = $realtobits(r);
    de   = b[62:52];
    fe   = 8'(de - 11'd896);
    keep = b[51:29];
    up   = b[28] & ((|b[27:0]) | keep[0]);
    v    = {fe, keep} + {30'd0, up};
    return {1'b0, v};
  endfunction

  function automatic void ref_sqrt(input logic [31:0] x, output logic [31:0] y,
                                   output logic inv, output int tol);
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    real         v;
    s = x[31]; e = x[30:23]; m = x[22:0];
    inv = 1'b0; tol = 0;
    if (e == 8'd0)       y = {s, 31'd0};
    else if (e == 8'hFF) begin
      if (m == 23'd0 && !s) y = 32'h7F80_0000;
      else begin
        y   = 32'h7FC0_0000;
        inv = (m == 23'd0) ? 1'b1 : ~m[22];
      end
    end else if (s) begin
      y = 32'h7FC0_0000; inv = 1'b1;
    end else begin
      v   = $bitstoreal({1'b0, 11'({3'd0, e} + 11'd896), m, 29'd0});
      y   = r2f($sqrt(v));
      tol = 1;
    end
  endfunction

  // One clock cycle: settle, check outputs, update the scoreboard, advance.
  task automatic step();
    exp_t e;
    logic [31:0] ey;
    logic        einv;
    int          etol;
    #1;
    last_acc = 0;
    if (rstn) begin
      chk("in_ready", 64'(in_ready), 64'(!out_valid || out_ready), 0);
      if (out_valid && q.size() == 0) chk("spurious_valid", 64'(out_valid), 64'd0, 0);
      if (out_valid && !out_ready && q.size() > 0) chk("hold_y", 64'(out_y), 64'(q[0].y), q[0].tol);
      if (out_valid && out_ready && q.size() > 0) begin
        e = q.pop_front();
        chk("y", 64'(out_y), 64'(e.y), e.tol);
        chk("tag", 64'(out_tag), 64'(e.tag), 0);
        chk("inv", 64'(out_inv), 64'(e.inv), 0);
        if (e.lat) chk("latency", 64'(cyc - e.acc), 64'(LAT), 0);
      end
    end
    if (!rstn || flush) q.delete();
    else if (in_valid && in_ready) begin
      ref_sqrt(in_x, ey, einv, etol);
      e.y = ey; e.inv = einv; e.tol = exact_mode ? 0 : etol;
      e.tag = in_tag; e.acc = cyc; e.lat = lat_mode;
      q.push_back(e);
      last_acc = 1;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] x, input logic [TAG_W-1:0] tag);
    in_valid = 1'b1; in_x = x; in_tag = tag;
    for (int i = 0; i < 100; i++) begin
      step();
      if (last_acc) break;
    end
    chk("issue_timeout", 64'(!last_acc), 64'd0, 0);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 200 && q.size() > 0; i++) step();
    chk("drain_timeout", 64'(q.size()), 64'd0, 0);
    q.delete();
    step(); step();
  endtask

  task automatic chk_reset_outs(input string tag);
    #1;
    chk({tag, "_valid"}, 64'(out_valid), 64'd0, 0);
    chk({tag, "_y"},     64'(out_y),     64'd0, 0);
    chk({tag, "_tag"},   64'(out_tag),   64'd0, 0);
    chk({tag, "_inv"},   64'(out_inv),   64'd0, 0);
    chk({tag, "_ready"}, 64'(in_ready),  64'd1, 0);
  endtask

  function automatic logic [31:0] rnd_norm();
    return {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  logic [31:0] spec_x [5] = '{32'hBF80_0000, 32'h7F80_0000, 32'h8000_0000,
                              32'h0000_0001, 32'h7FA0_0000};

  initial begin
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_x = '0; in_tag = '0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    rstn = 1'b1;
    chk_reset_outs("reset");

    // latency
    lat_mode = 1; exact_mode = 1;
    issue(32'h4080_0000, 5'd3);
    drain();

    // throughput and ordering
    exact_mode = 0; issue(32'h4000_0000, 5'd1);
    exact_mode = 1; issue(32'h4110_0000, 5'd2);
    issue(32'h3E80_0000, 5'd4);
    drain();

    // specials
    for (int i = 0; i < 5; i++) issue(spec_x[i], 5'(i + 8));
    drain();
    exact_mode = 0; lat_mode = 0;

    // stall mid-stream
    for (int i = 0; i < 8; i++) begin
      if (i == 6) begin
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          in_valid = 1'b1; in_x = rnd_norm();
          #1 chk("stall_ready", 64'(in_ready), 64'd0, 0);
          step();
        end
        out_ready = 1'b1;
      end
      issue(rnd_norm(), 5'(i));
    end
    drain();

    // flush with ops in flight and a same-cycle input
    for (int i = 0; i < 3; i++) issue(rnd_norm(), 5'(20 + i));
    in_valid = 1'b1; in_x = 32'h4080_0000; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    repeat (LAT + 3) step();
    lat_mode = 1; issue(32'h4110_0000, 5'd7); drain(); lat_mode = 0;

    // reset with ops in flight
    for (int i = 0; i < 3; i++) issue(rnd_norm(), 5'(24 + i));
    in_valid = 1'b1; in_x = 32'h4080_0000; rstn = 1'b0;
    step();
    rstn = 1'b1; in_valid = 1'b0;
    chk_reset_outs("midreset");
    repeat (LAT + 3) step();
    lat_mode = 1; issue(32'h3E80_0000, 5'd9); drain(); lat_mode = 0;

    // random sweep with random back-pressure
    for (int i = 0; i < 4000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_x      = ($urandom_range(0, 9) == 0) ? 32'($urandom) : rnd_norm();
      in_tag    = TAG_W'($urandom);
      step();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
